// File: rtl/ir_transmitter_multi.sv
// rtl/ir_transmitter_multi.sv - bus-mapped multi-channel IR car-control packet transmitter
module ir_transmitter_multi #(
    parameter logic [7:0] BASE_ADDR    = 8'h90,
    parameter int         NUM_CH       = 4,
    parameter int         CARRIER_HALF = 1389,
    parameter int         START_BURST  = 88,
    parameter int         CARSEL_BURST = 22,
    parameter int         GAP          = 40,
    parameter int         ONE_BURST    = 44,
    parameter int         ZERO_BURST   = 22,
    parameter int         TICK_CYCLES  = 10_000_000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        BUS_ADDR,
    inout  wire  [7:0]        BUS_DATA,
    input  logic              BUS_WE,
    output logic [NUM_CH-1:0] IR_LED
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_GAP_S  = 3'd2;
    localparam logic [2:0] S_CARSEL = 3'd3;
    localparam logic [2:0] S_GAP_C  = 3'd4;
    localparam logic [2:0] S_BIT    = 3'd5;
    localparam logic [2:0] S_GAP_B  = 3'd6;

    localparam int CAR_PERIOD = 2 * CARRIER_HALF;
    localparam int CW         = $clog2(CAR_PERIOD + 1);
    localparam logic [CW-1:0] CAR_LAST = CW'(CAR_PERIOD - 1);
    localparam logic [CW-1:0] CAR_HI   = CW'(CARRIER_HALF);

    localparam int MAX_A = (START_BURST > CARSEL_BURST) ? START_BURST : CARSEL_BURST;
    localparam int MAX_B = (ONE_BURST > ZERO_BURST) ? ONE_BURST : ZERO_BURST;
    localparam int MAX_C = (GAP > MAX_B) ? GAP : MAX_B;
    localparam int MAX_P = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int PW    = $clog2(MAX_P + 1);

    localparam int TW = $clog2(TICK_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    // Only six CTRL bits exist for the mask; wider channel counts leave the rest always on.
    localparam int MW = (NUM_CH < 6) ? NUM_CH : 6;

    localparam logic [7:0] ADDR_CMD  = BASE_ADDR;
    localparam logic [7:0] ADDR_CTRL = BASE_ADDR + 8'd1;
    localparam logic [7:0] ADDR_STAT = BASE_ADDR + 8'd2;

    logic [3:0]    cmd_q;
    logic          periodic_q;
    logic [MW-1:0] mask_q;
    logic          overrun_q;
    logic [TW-1:0] tick_cnt_q;
    logic [2:0]    state_q;
    logic [CW-1:0] car_cnt_q;
    logic [PW-1:0] per_cnt_q;
    logic [1:0]    bit_idx_q;
    logic [3:0]    sh_cmd_q;
    logic [MW-1:0] sh_mask_q;
    logic          rd_en_q;
    logic [7:0]    rd_data_q;

    logic          wr_cmd, wr_ctrl, oneshot, tick, trigger, busy;
    logic          car_last, seg_done, burst, led_on, rd_hit;
    logic [PW-1:0] seg_len;
    logic [5:0]    mask_rd;
    logic [7:0]    rd_mux;

    assign wr_cmd   = BUS_WE && (BUS_ADDR == ADDR_CMD);
    assign wr_ctrl  = BUS_WE && (BUS_ADDR == ADDR_CTRL);
    assign oneshot  = wr_ctrl && BUS_DATA[1];
    assign tick     = periodic_q && (tick_cnt_q == TICK_LAST);
    assign trigger  = tick || oneshot;
    assign busy     = (state_q != S_IDLE);
    assign car_last = (car_cnt_q == CAR_LAST);
    assign seg_done = car_last && (per_cnt_q == seg_len - PW'(1));
    assign burst    = (state_q == S_START) || (state_q == S_CARSEL) || (state_q == S_BIT);
    assign led_on   = burst && (car_cnt_q < CAR_HI);

    always_comb begin
        seg_len = PW'(1);
        case (state_q)
            S_START:  seg_len = PW'(START_BURST);
            S_CARSEL: seg_len = PW'(CARSEL_BURST);
            S_BIT:    seg_len = sh_cmd_q[bit_idx_q] ? PW'(ONE_BURST) : PW'(ZERO_BURST);
            S_GAP_S, S_GAP_C, S_GAP_B: seg_len = PW'(GAP);
            default:  seg_len = PW'(1);
        endcase
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_led
        if (k < MW) begin : g_masked
            assign IR_LED[k] = led_on && sh_mask_q[k];
        end else begin : g_fixed
            assign IR_LED[k] = led_on;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cmd_q      <= '0;
            periodic_q <= 1'b0;
            mask_q     <= '0;
            overrun_q  <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            if (wr_cmd)
                cmd_q <= BUS_DATA[3:0];
            if (wr_ctrl) begin
                periodic_q <= BUS_DATA[0];
                mask_q     <= BUS_DATA[2 +: MW];
            end
            // A dropped trigger wins over the clear carried by the same CTRL write.
            if (trigger && busy)
                overrun_q <= 1'b1;
            else if (wr_ctrl)
                overrun_q <= 1'b0;
            if (!periodic_q || tick)
                tick_cnt_q <= '0;
            else
                tick_cnt_q <= tick_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            car_cnt_q <= '0;
            per_cnt_q <= '0;
            bit_idx_q <= '0;
            sh_cmd_q  <= '0;
            sh_mask_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (trigger) begin
                state_q   <= S_START;
                car_cnt_q <= '0;
                per_cnt_q <= '0;
                bit_idx_q <= '0;
                sh_cmd_q  <= cmd_q;
                sh_mask_q <= wr_ctrl ? BUS_DATA[2 +: MW] : mask_q;
            end
        end else begin
            car_cnt_q <= car_last ? '0 : car_cnt_q + CW'(1);
            if (seg_done) begin
                per_cnt_q <= '0;
                case (state_q)
                    S_START:  state_q <= S_GAP_S;
                    S_GAP_S:  state_q <= S_CARSEL;
                    S_CARSEL: state_q <= S_GAP_C;
                    S_GAP_C:  state_q <= S_BIT;
                    S_BIT:    state_q <= S_GAP_B;
                    S_GAP_B: begin
                        if (bit_idx_q == 2'd3) begin
                            state_q <= S_IDLE;
                        end else begin
                            bit_idx_q <= bit_idx_q + 2'd1;
                            state_q   <= S_BIT;
                        end
                    end
                    default:  state_q <= S_IDLE;
                endcase
            end else if (car_last) begin
                per_cnt_q <= per_cnt_q + PW'(1);
            end
        end
    end

    assign mask_rd = 6'(mask_q);
    assign rd_hit  = !BUS_WE && ((BUS_ADDR == ADDR_CMD) || (BUS_ADDR == ADDR_CTRL) ||
                                 (BUS_ADDR == ADDR_STAT));

    always_comb begin
        rd_mux = 8'h00;
        case (BUS_ADDR)
            ADDR_CMD:  rd_mux = {4'h0, cmd_q};
            ADDR_CTRL: rd_mux = {mask_rd, 1'b0, periodic_q};
            ADDR_STAT: rd_mux = {6'h00, overrun_q, busy};
            default:   rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_en_q   <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            rd_en_q   <= rd_hit;
            rd_data_q <= rd_mux;
        end
    end

    assign BUS_DATA = rd_en_q ? rd_data_q : 8'bz;
endmodule

// File: tb/tb_ir_transmitter_multi.sv
// tb/tb_ir_transmitter_multi.sv - scoreboard bench for ir_transmitter_multi
`timescale 1ns/100ps
module tb_ir_transmitter_multi;
    localparam logic [7:0] BASE = 8'h90;
    localparam int H = 2, P_START = 4, P_CARSEL = 2, P_GAP = 2, P_ONE = 3, P_ZERO = 1;
    localparam int TICK = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       we = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [3:0] led;
    tri1  [7:0] bus_data;

    assign bus_data = we ? wdata : 8'bz;

    ir_transmitter_multi #(
        .BASE_ADDR(BASE), .NUM_CH(4), .CARRIER_HALF(H), .START_BURST(P_START),
        .CARSEL_BURST(P_CARSEL), .GAP(P_GAP), .ONE_BURST(P_ONE), .ZERO_BURST(P_ZERO),
        .TICK_CYCLES(TICK)
    ) dut (
        .CLK(clk), .RESET(rst_n), .BUS_ADDR(addr), .BUS_DATA(bus_data),
        .BUS_WE(we), .IR_LED(led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input logic ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    typedef struct { int t0; logic [3:0] cmd; logic [5:0] mask; } pkt_t;
    typedef struct { int at; logic [7:0] data; } rd_t;
    pkt_t pkt_q[$];
    rd_t  rd_q[$];

    // Reference model state: registers as seen from the bus, plus when the current packet ends.
    logic [3:0] m_cmd;
    logic [5:0] m_mask;
    logic       m_periodic, m_overrun;
    int         m_busy_end, m_tick_next;
    logic       prev_rd = 1'b0;
    logic       in_pkt = 1'b0;

    function automatic int pkt_len(input logic [3:0] c);
        int s = P_START + P_CARSEL + 6 * P_GAP;
        for (int i = 0; i < 4; i++) s += c[i] ? P_ONE : P_ZERO;
        return 2 * H * s;
    endfunction

    function automatic logic [3:0] exp_led(input logic [3:0] c, input logic [5:0] m, input int o);
        int seg[12];
        int acc = 0;
        seg = '{P_START, P_GAP, P_CARSEL, P_GAP,
                c[0] ? P_ONE : P_ZERO, P_GAP, c[1] ? P_ONE : P_ZERO, P_GAP,
                c[2] ? P_ONE : P_ZERO, P_GAP, c[3] ? P_ONE : P_ZERO, P_GAP};
        for (int s = 0; s < 12; s++) begin
            if (o < acc + seg[s] * 2 * H)
                return ((s % 2 == 0) && ((o % (2 * H)) < H)) ? m[3:0] : 4'h0;
            acc += seg[s] * 2 * H;
        end
        return 4'h0;
    endfunction

    function automatic void model_reset();
        m_cmd = 4'h0; m_mask = 6'h00; m_periodic = 1'b0; m_overrun = 1'b0;
        m_busy_end = -1; m_tick_next = 0;
        pkt_q.delete(); rd_q.delete(); prev_rd = 1'b0;
    endfunction

    function automatic void model_step(input int c, input logic w, input logic [7:0] a, input logic [7:0] d);
        logic busy, tick, wr_ctrl, one, ovr_set;
        logic [5:0] pm;
        busy = (c <= m_busy_end);
        if (!w && a == BASE)            rd_q.push_back('{c + 1, {4'h0, m_cmd}});
        if (!w && a == BASE + 8'd1)     rd_q.push_back('{c + 1, {2'b00, m_mask[3:0], 1'b0, m_periodic}});
        if (!w && a == BASE + 8'd2)     rd_q.push_back('{c + 1, {6'h00, m_overrun, busy}});
        tick = m_periodic && (c == m_tick_next);
        if (tick) m_tick_next = c + TICK;
        wr_ctrl = w && (a == BASE + 8'd1);
        one = wr_ctrl && d[1];
        ovr_set = 1'b0;
        if (tick || one) begin
            if (busy) begin
                ovr_set = 1'b1;
            end else begin
                pm = wr_ctrl ? d[7:2] : m_mask;
                if (pm[3:0] != 4'h0) pkt_q.push_back('{c + 1, m_cmd, pm});
                m_busy_end = c + pkt_len(m_cmd);
            end
        end
        if (ovr_set) m_overrun = 1'b1;
        else if (wr_ctrl) m_overrun = 1'b0;
        if (w && a == BASE) m_cmd = d[3:0];
        if (wr_ctrl) begin
            if (d[0] && !m_periodic) m_tick_next = c + TICK;
            m_periodic = d[0];
            m_mask = d[7:2];
        end
    endfunction

    task automatic cyc_drive(input logic w, input logic [7:0] a, input logic [7:0] d);
        if (w && prev_rd) begin
            we = 1'b0; addr = 8'h00; wdata = 8'h00;
            model_step(cyc, 1'b0, 8'h00, 8'h00);
            @(posedge clk); #1;
        end
        we = w; addr = a; wdata = d;
        model_step(cyc, w, a, d);
        prev_rd = !w && (a >= BASE) && (a <= BASE + 8'd2);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_drive(1'b0, 8'h00, 8'h00);
    endtask

    // LED monitor: a packet appears when any LED rises while idle; compare it to the next expected one.
    initial begin : led_mon
        pkt_t p;
        int   o, errs, plen;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_pkt = 1'b0;
            end else begin
                if (!in_pkt && led != 4'h0) begin
                    if (pkt_q.size() == 0) begin
                        chk("led_unexpected", 1'b0, led, 0);
                    end else begin
                        p = pkt_q.pop_front();
                        in_pkt = 1'b1;
                        errs = 0;
                        plen = pkt_len(p.cmd);
                        chk("pkt_start_cycle", cyc == p.t0, cyc, p.t0);
                    end
                end
                if (in_pkt) begin
                    o = cyc - p.t0;
                    if (led != exp_led(p.cmd, p.mask, o)) errs++;
                    if (o >= plen - 1) begin
                        chk("pkt_waveform", errs == 0, errs, 0);
                        in_pkt = 1'b0;
                    end
                end
            end
        end
    end

    // Bus monitor: the pull-up makes an undriven bus read 8'hFF, a value no register can return.
    initial begin : bus_mon
        rd_t r;
        forever begin
            @(negedge clk);
            if (rst_n && !we) begin
                if (rd_q.size() > 0 && rd_q[0].at == cyc) begin
                    r = rd_q.pop_front();
                    chk("bus_read", bus_data == r.data, bus_data, r.data);
                end else if (bus_data != 8'hFF) begin
                    chk("bus_undriven", 1'b0, bus_data, 8'hFF);
                end
            end
        end
    end

    initial begin : stim
        int op;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_led", led == 4'h0, led, 0);
        rst_n = 1'b1;

        cyc_drive(1'b0, BASE, 8'h00);
        cyc_drive(1'b0, BASE + 8'd1, 8'h00);
        cyc_drive(1'b0, BASE + 8'd2, 8'h00);
        idle(1);

        // CMD=1010, LED0 only, BUSY sampled every cycle through the packet
        cyc_drive(1'b1, BASE, 8'h0A);
        cyc_drive(1'b1, BASE + 8'd1, 8'h06);
        for (int i = 0; i < 106; i++) cyc_drive(1'b0, BASE + 8'd2, 8'h00);
        idle(4);

        // periodic on all four LEDs
        cyc_drive(1'b1, BASE + 8'd1, 8'h3D);
        for (int i = 0; i < 13; i++) begin
            idle(49);
            cyc_drive(1'b0, BASE + 8'd2, 8'h00);
        end
        cyc_drive(1'b1, BASE + 8'd1, 8'h3C);
        idle(120);

        // oneshot while busy sets OVERRUN; next CTRL write clears it
        cyc_drive(1'b1, BASE, 8'h05);
        cyc_drive(1'b1, BASE + 8'd1, 8'h3E);
        idle(10);
        cyc_drive(1'b1, BASE + 8'd1, 8'h3E);
        cyc_drive(1'b0, BASE + 8'd2, 8'h00);
        cyc_drive(1'b1, BASE + 8'd1, 8'h3C);
        cyc_drive(1'b0, BASE + 8'd2, 8'h00);
        idle(110);
        cyc_drive(1'b0, BASE + 8'd2, 8'h00);

        // CMD changed mid-packet affects only the next packet
        cyc_drive(1'b1, BASE, 8'h00);
        cyc_drive(1'b1, BASE + 8'd1, 8'h3E);
        idle(30);
        cyc_drive(1'b1, BASE, 8'h0F);
        idle(80);
        cyc_drive(1'b1, BASE + 8'd1, 8'h3E);
        idle(130);

        // high-Z outside the window, one-cycle read data inside it
        cyc_drive(1'b0, BASE + 8'd3, 8'h00);
        chk("hiz_base3", bus_data == 8'hFF, bus_data, 8'hFF);
        cyc_drive(1'b0, BASE, 8'h00);
        cyc_drive(1'b0, 8'h00, 8'h00);
        chk("read_one_cycle", bus_data == 8'hFF, bus_data, 8'hFF);
        idle(2);

        // asynchronous reset in the middle of the car-select burst
        cyc_drive(1'b1, BASE, 8'h09);
        cyc_drive(1'b1, BASE + 8'd1, 8'h3E);
        idle(25);
        chk("led_before_reset", led == 4'hF, led, 4'hF);
        we = 1'b0; addr = 8'h00;
        #2;
        rst_n = 1'b0;
        #0.1;
        chk("led_async_reset", led == 4'h0, led, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc_drive(1'b0, BASE + 8'd2, 8'h00);
        cyc_drive(1'b0, BASE, 8'h00);
        cyc_drive(1'b0, BASE + 8'd1, 8'h00);
        idle(2);

        for (int i = 0; i < 120; i++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: cyc_drive(1'b1, BASE, 8'($urandom));
                1: cyc_drive(1'b1, BASE + 8'd1,
                             {6'($urandom), 1'b0, ($urandom_range(0, 2) == 0)});
                2: cyc_drive(1'b1, BASE + 8'd1, {6'($urandom), 2'b10});
                3: cyc_drive(1'b0, BASE - 8'd2 + 8'($urandom_range(0, 5)), 8'h00);
                default: idle(int'($urandom_range(1, 60)));
            endcase
        end
        cyc_drive(1'b1, BASE + 8'd1, 8'h00);
        idle(150);

        chk("pkt_queue_empty", pkt_q.size() == 0, pkt_q.size(), 0);
        chk("rd_queue_empty", rd_q.size() == 0, rd_q.size(), 0);
        chk("pkt_closed", !in_pkt, in_pkt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
